fpmul_arbiter: RTL and testbench

FPMUL_ARBITER -- requirements
Module: fpmul_arbiter

---
 rtl/fpmul_arbiter_if.sv | 40 ++++
 rtl/fpmul_arbiter.sv | 119 +++++++++++
 tb/tb_fpmul_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fpmul_arbiter_if.sv
// Bundle between the four requesters, the shared multiplier and fpmul_arbiter.
// ISSUE_CNT is present only when FPMUL_ARB_STATS_EN is defined.
interface fpmul_arbiter_if;
  logic [3:0]   REQ;
  logic [127:0] REQ_A;
  logic [127:0] REQ_B;
  logic         HOLD;
  logic [3:0]   GNT;
  logic         MUL_ACT;
  logic         MUL_TAG;
  logic [31:0]  MUL_A;
  logic [31:0]  MUL_B;
  logic         MUL_RDY;
  logic         MUL_TAGO;
  logic [31:0]  MUL_R;
  logic [3:0]   RVLD;
  logic [31:0]  RES;
  logic         ERR;
`ifdef FPMUL_ARB_STATS_EN
  logic [63:0]  ISSUE_CNT;

  modport master (
    output REQ, REQ_A, REQ_B, HOLD, MUL_RDY, MUL_TAGO, MUL_R,
    input  GNT, MUL_ACT, MUL_TAG, MUL_A, MUL_B, RVLD, RES, ERR, ISSUE_CNT
  );
  modport slave (
    input  REQ, REQ_A, REQ_B, HOLD, MUL_RDY, MUL_TAGO, MUL_R,
    output GNT, MUL_ACT, MUL_TAG, MUL_A, MUL_B, RVLD, RES, ERR, ISSUE_CNT
  );
`else
  modport master (
    output REQ, REQ_A, REQ_B, HOLD, MUL_RDY, MUL_TAGO, MUL_R,
    input  GNT, MUL_ACT, MUL_TAG, MUL_A, MUL_B, RVLD, RES, ERR
  );
  modport slave (
    input  REQ, REQ_A, REQ_B, HOLD, MUL_RDY, MUL_TAGO, MUL_R,
    output GNT, MUL_ACT, MUL_TAG, MUL_A, MUL_B, RVLD, RES, ERR
  );
`endif
endinterface

// File: rtl/fpmul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among four requesters.
// Define FPMUL_ARB_STATS_EN to add saturating per-requester issue counters (ISSUE_CNT).
module fpmul_arbiter #(
  parameter int unsigned LAT   = 3,
  parameter int unsigned DEPTH = 4
) (
  input logic            CLK,
  input logic            RESET,
  fpmul_arbiter_if.slave bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  if (DEPTH < LAT + 1) begin : g_depth_chk
    $error("fpmul_arbiter: DEPTH must be at least LAT+1");
  end

  logic [1:0]      ptr_q;
  logic [CntW-1:0] drain_q;
  logic [2:0]      fifo_q [DEPTH];  // {toggle, id}
  logic [PtrW-1:0] wr_q, rd_q;
  logic [CntW-1:0] cnt_q;
  logic            tog_q, act_q, err_q;
  logic [31:0]     a_q, b_q, res_q;
  logic [3:0]      rvld_q;

  logic            in_drain, pop, push, found;
  logic [1:0]      win, idx;
  logic [3:0]      gnt;
  logic [2:0]      head;

  assign in_drain = (drain_q != '0);
  assign head     = fifo_q[rd_q];
  assign pop      = bus.MUL_RDY && !in_drain && (cnt_q != '0);

  always_comb begin
    gnt   = '0;
    win   = '0;
    idx   = ptr_q;
    found = 1'b0;
    push  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = ptr_q + k[1:0];
      if (!found && bus.REQ[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    // A same-cycle pop frees a slot, so a full FIFO can still accept a push.
    push = !RESET && !bus.HOLD && found && !in_drain &&
           ((cnt_q - CntW'(pop)) < CntW'(DEPTH));
    if (push) gnt[win] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ptr_q   <= '0;
      drain_q <= CntW'(DEPTH);
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      tog_q   <= 1'b0;
      act_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      rvld_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (in_drain) drain_q <= drain_q - 1'b1;
      act_q  <= push;
      rvld_q <= '0;
      cnt_q  <= cnt_q + CntW'(push) - CntW'(pop);
      if (push) begin
        ptr_q <= win + 2'd1;
        a_q   <= bus.REQ_A[{win, 5'b0} +: 32];
        b_q   <= bus.REQ_B[{win, 5'b0} +: 32];
        tog_q <= ~tog_q;
        wr_q  <= (wr_q == PtrW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      end
      if (pop) begin
        rd_q              <= (rd_q == PtrW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
        res_q             <= bus.MUL_R;
        rvld_q[head[1:0]] <= 1'b1;
        if (bus.MUL_TAGO != head[2]) err_q <= 1'b1;
      end else if (bus.MUL_RDY && !in_drain) begin
        err_q <= 1'b1;
      end
    end
  end

  // Entry payload needs no reset; occupancy is tracked by cnt_q.
  always_ff @(posedge CLK) begin
    if (push) fifo_q[wr_q] <= {~tog_q, win};
  end

  assign bus.GNT     = gnt;
  assign bus.MUL_ACT = act_q;
  assign bus.MUL_TAG = tog_q;
  assign bus.MUL_A   = a_q;
  assign bus.MUL_B   = b_q;
  assign bus.RVLD    = rvld_q;
  assign bus.RES     = res_q;
  assign bus.ERR     = err_q;

`ifdef FPMUL_ARB_STATS_EN
  logic [15:0] stat_q [4];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 4; i++) stat_q[i] <= '0;
    end else if (push && (stat_q[win] != 16'hFFFF)) begin
      stat_q[win] <= stat_q[win] + 16'd1;
    end
  end

  assign bus.ISSUE_CNT = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
`endif
endmodule

// File: tb/tb_fpmul_arbiter.sv
// Directed bench for fpmul_arbiter with a 3-cycle multiplier model.
// The model adds biased exponents, exact when one operand's mantissa is zero.
module tb_fpmul_arbiter;
  logic CLK = 1'b0;
  logic RESET;
  logic inj_rdy, flip_tag;
  int   n_checks, n_fail;

  logic [2:0]  s_act, s_tag;
  logic [31:0] s_res [3];
  logic [31:0] prod [4];
  logic [3:0]  exp_gnt [14];
  logic [3:0]  exp_rvld [14];

  fpmul_arbiter_if bus ();

  fpmul_arbiter #(.LAT(3), .DEPTH(4)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  always #5 CLK = ~CLK;

  always_ff @(posedge CLK) begin
    s_act    <= {s_act[1:0], bus.MUL_ACT};
    s_tag    <= {s_tag[1:0], bus.MUL_TAG};
    s_res[0] <= bus.MUL_A + bus.MUL_B - 32'h3F80_0000;
    s_res[1] <= s_res[0];
    s_res[2] <= s_res[1];
  end

  assign bus.MUL_RDY  = s_act[2] | inj_rdy;
  assign bus.MUL_TAGO = s_tag[2] ^ flip_tag;
  assign bus.MUL_R    = s_act[2] ? s_res[2] : 32'h1234_5678;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RESET    = 1'b1;
    inj_rdy  = 1'b0;
    flip_tag = 1'b0;
    bus.REQ  = '0;
    bus.HOLD = 1'b0;
    // A = 2.0 everywhere; B3..B0 = 0.5, 5.0, 1.5, 3.0
    bus.REQ_A = {4{32'h4000_0000}};
    bus.REQ_B = {32'h3F00_0000, 32'h40A0_0000, 32'h3FC0_0000, 32'h4040_0000};
    prod      = '{32'h40C0_0000, 32'h4040_0000, 32'h4120_0000, 32'h3F80_0000};
    exp_gnt   = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h2, 4'h4,
                  4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    exp_rvld  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4,
                  4'h8, 4'h1, 4'h0, 4'h2, 4'h4, 4'h0};

    // Reset state, with requests present to show GNT is gated.
    repeat (5) @(negedge CLK);
    bus.REQ = 4'b1111;
    #1;
    check("rst_gnt", 64'(bus.GNT), 64'(0));
    check("rst_act", 64'(bus.MUL_ACT), 64'(0));
    check("rst_tag", 64'(bus.MUL_TAG), 64'(0));
    check("rst_mul_a", 64'(bus.MUL_A), 64'(0));
    check("rst_mul_b", 64'(bus.MUL_B), 64'(0));
    check("rst_rvld", 64'(bus.RVLD), 64'(0));
    check("rst_res", 64'(bus.RES), 64'(0));
    check("rst_err", 64'(bus.ERR), 64'(0));

    // Drain window: stray MUL_RDY ignored, grants blocked for 4 cycles.
    @(negedge CLK); RESET = 1'b0; bus.REQ = '0;
    @(negedge CLK); inj_rdy = 1'b1;
    @(negedge CLK); inj_rdy = 1'b0; #1;
    check("drain_rdy_err", 64'(bus.ERR), 64'(0));
    check("drain_rdy_rvld", 64'(bus.RVLD), 64'(0));
    @(negedge CLK); bus.REQ = 4'b0001; #1;
    check("drain_gnt", 64'(bus.GNT), 64'(0));
    @(negedge CLK); #1;
    check("first_gnt", 64'(bus.GNT), 64'(4'b0001));
    @(negedge CLK); bus.REQ = '0; #1;
    check("first_act", 64'(bus.MUL_ACT), 64'(1));
    check("first_mul_a", 64'(bus.MUL_A), 64'(32'h4000_0000));
    check("first_mul_b", 64'(bus.MUL_B), 64'(32'h4040_0000));
    check("first_tag", 64'(bus.MUL_TAG), 64'(1));
    @(negedge CLK); #1;
    check("act_drop", 64'(bus.MUL_ACT), 64'(0));
    repeat (3) @(negedge CLK); #1;
    check("first_rvld", 64'(bus.RVLD), 64'(4'b0001));
    check("first_res", 64'(bus.RES), 64'(32'h40C0_0000));
    check("first_err", 64'(bus.ERR), 64'(0));
    @(negedge CLK); #1;
    check("rvld_pulse", 64'(bus.RVLD), 64'(0));
    check("res_hold", 64'(bus.RES), 64'(32'h40C0_0000));

    // Pointer is 1: lone requester 3 wins and wraps the pointer to 0.
    @(negedge CLK); bus.REQ = 4'b1000; #1;
    check("wrap_gnt", 64'(bus.GNT), 64'(4'b1000));
    @(negedge CLK); bus.REQ = '0;
    repeat (4) @(negedge CLK); #1;
    check("wrap_rvld", 64'(bus.RVLD), 64'(4'b1000));
    check("wrap_res", 64'(bus.RES), 64'(32'h3F80_0000));
    repeat (2) @(negedge CLK);

    // All four requesting for 4 cycles from pointer 0.
    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      bus.REQ = (i < 4) ? 4'b1111 : 4'b0000;
      #1;
      if (i < 4) check("rr_gnt", 64'(bus.GNT), 64'(4'b0001 << i));
      if (i >= 5) begin
        check("rr_rvld", 64'(bus.RVLD), 64'(4'b0001 << (i - 5)));
        check("rr_res", 64'(bus.RES), 64'(prod[i-5]));
      end
    end
    repeat (2) @(negedge CLK);

    // Continuous requests with one HOLD cycle.
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      bus.REQ  = (i < 8) ? 4'b1111 : 4'b0000;
      bus.HOLD = (i == 5);
      #1;
      check("hold_gnt", 64'(bus.GNT), 64'(exp_gnt[i]));
      check("hold_rvld", 64'(bus.RVLD), 64'(exp_rvld[i]));
      if (i == 5) check("hold_act_before", 64'(bus.MUL_ACT), 64'(1));
      if (i == 6) check("hold_act_after", 64'(bus.MUL_ACT), 64'(0));
    end
    check("hold_err", 64'(bus.ERR), 64'(0));

    // Spurious MUL_RDY, then a result returning with the wrong tag.
    @(negedge CLK); inj_rdy = 1'b1;
    @(negedge CLK); inj_rdy = 1'b0; bus.REQ = 4'b0010; flip_tag = 1'b1; #1;
    check("empty_rdy_err", 64'(bus.ERR), 64'(1));
    check("empty_rdy_rvld", 64'(bus.RVLD), 64'(0));
    check("empty_rdy_res", 64'(bus.RES), 64'(32'h4120_0000));
    check("tag_gnt", 64'(bus.GNT), 64'(4'b0010));
    @(negedge CLK); bus.REQ = '0;
    repeat (4) @(negedge CLK); #1;
    check("tag_rvld", 64'(bus.RVLD), 64'(4'b0010));
    check("tag_res", 64'(bus.RES), 64'(32'h4040_0000));
    check("err_sticky", 64'(bus.ERR), 64'(1));

    // Reset with three multiplies in flight.
    @(negedge CLK); flip_tag = 1'b0; bus.REQ = 4'b1111; #1;
    check("pre_rst_gnt", 64'(bus.GNT), 64'(4'b0100));
    repeat (2) @(negedge CLK);
    @(negedge CLK); RESET = 1'b1; #1;
    check("mid_rst_gnt", 64'(bus.GNT), 64'(0));
    @(negedge CLK); RESET = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge CLK);
      if (i == 5) bus.REQ = '0;
      #1;
      check("rst_drain_gnt", 64'(bus.GNT), 64'((i == 4) ? 4'b0001 : 4'b0000));
      check("rst_drain_rvld", 64'(bus.RVLD), 64'(0));
      check("rst_drain_err", 64'(bus.ERR), 64'(0));
    end
    @(negedge CLK); #1;
    check("post_rst_rvld", 64'(bus.RVLD), 64'(4'b0001));
    check("post_rst_res", 64'(bus.RES), 64'(32'h40C0_0000));

`ifdef FPMUL_ARB_STATS_EN
    @(negedge CLK); RESET = 1'b1;
    @(negedge CLK); RESET = 1'b0; #1;
    check("stat_rst", bus.ISSUE_CNT, 64'(0));
    bus.REQ = 4'b0100;
    repeat (70004) @(negedge CLK);
    bus.REQ = '0;
    repeat (8) @(negedge CLK); #1;
    check("stat_sat", bus.ISSUE_CNT, {16'h0000, 16'hFFFF, 32'h0000_0000});
    check("stat_err", 64'(bus.ERR), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
